// File: rtl/vx_elastic_pipe.sv
// rtl/vx_elastic_pipe.sv - multi-stage valid/ready pipeline with bubble collapsing, flush and occupancy count
module vx_elastic_pipe #(
  parameter int DATAW  = 1,
  parameter int RESETW = DATAW,
  parameter int DEPTH  = 1,
  parameter int CNTW   = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [DATAW-1:0] data_out,
  output logic [CNTW-1:0]  count
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign valid_out = valid_in & ~flush;
    assign ready_in  = ready_out & ~flush;
    assign data_out  = data_in;
    assign count     = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0]            v_next;
    logic [DEPTH-1:0]            vin;
    logic [DEPTH-1:0]            rdy;
    logic [DEPTH-1:0]            ld;
    logic [DEPTH-1:0][DATAW-1:0] d;
    logic [DEPTH-1:0][DATAW-1:0] src;
    logic [CNTW-1:0]             cnt_next;

    // A stage is ready when empty or when everything ahead of it can move.
    always_comb begin : readiness
      logic r;
      r   = ready_out;
      rdy = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        r      = ~v[i] | r;
        rdy[i] = r;
      end
    end

    always_comb begin
      vin    = '0;
      src    = '0;
      vin[0] = valid_in;
      src[0] = data_in;
      for (int i = 1; i < DEPTH; i++) begin
        vin[i] = v[i-1];
        src[i] = d[i-1];
      end
    end

    always_comb begin
      v_next = v;
      if (flush) begin
        v_next = '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rdy[i]) v_next[i] = vin[i];
        end
      end
    end

    always_comb begin
      cnt_next = '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt_next = cnt_next + CNTW'(v_next[i]);
      end
    end

    // Payload only toggles when a valid entry actually lands in the stage.
    assign ld = rdy & vin & {DEPTH{~flush}};

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v     <= '0;
        count <= '0;
      end else begin
        v     <= v_next;
        count <= cnt_next;
      end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (RESETW > 0) begin : g_hi
        logic [RESETW-1:0] q;
        always_ff @(posedge clk or posedge reset) begin
          if (reset)      q <= '0;
          else if (ld[i]) q <= src[i][DATAW-1 -: RESETW];
        end
        assign d[i][DATAW-1 -: RESETW] = q;
      end
      if (RESETW < DATAW) begin : g_lo
        logic [DATAW-RESETW-1:0] q;
        always_ff @(posedge clk) begin
          if (ld[i]) q <= src[i][DATAW-RESETW-1:0];
        end
        assign d[i][DATAW-RESETW-1:0] = q;
      end
    end

    assign valid_out = v[DEPTH-1] & ~flush;
    assign ready_in  = rdy[0] & ~flush;
    assign data_out  = d[DEPTH-1];
  end

endmodule

// File: tb/tb_vx_elastic_pipe.sv
// tb/tb_vx_elastic_pipe.sv - randomized and directed bench for vx_elastic_pipe against a positional queue model
module tb_vx_elastic_pipe;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_out = 1'b0;
  logic [7:0] data_in = 8'h00;

  logic       vo0, vo1, vo2, ri0, ri1, ri2;
  logic [7:0] do0, do1, do2;
  logic [1:0] c0;
  logic [2:0] c1;
  logic [0:0] c2;

  logic       a_vo [3];
  logic       a_ri [3];
  logic [7:0] a_do [3];
  logic [2:0] a_cnt[3];

  assign a_vo[0] = vo0; assign a_vo[1] = vo1; assign a_vo[2] = vo2;
  assign a_ri[0] = ri0; assign a_ri[1] = ri1; assign a_ri[2] = ri2;
  assign a_do[0] = do0; assign a_do[1] = do1; assign a_do[2] = do2;
  assign a_cnt[0] = {1'b0, c0}; assign a_cnt[1] = c1; assign a_cnt[2] = {2'b00, c2};

  vx_elastic_pipe #(.DATAW(8), .RESETW(4), .DEPTH(3)) u0 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_in(ri0),
    .data_in(data_in), .valid_out(vo0), .ready_out(ready_out), .data_out(do0), .count(c0));
  vx_elastic_pipe #(.DATAW(8), .RESETW(8), .DEPTH(4)) u1 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_in(ri1),
    .data_in(data_in), .valid_out(vo1), .ready_out(ready_out), .data_out(do1), .count(c1));
  vx_elastic_pipe #(.DATAW(8), .RESETW(0), .DEPTH(0)) u2 (
    .clk(clk), .reset(reset), .flush(flush), .valid_in(valid_in), .ready_in(ri2),
    .data_in(data_in), .valid_out(vo2), .ready_out(ready_out), .data_out(do2), .count(c2));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: per pipe, an ordered list of entries (oldest first) with their stage position.
  int         dep[3] = '{3, 4, 0};
  int         n[3] = '{0, 0, 0};
  int         pos[3][8];
  logic [7:0] dat[3][8];
  bit         mv[3][8];
  bit         p_vo[3], p_ri[3];
  logic [7:0] p_do[3];
  logic [7:0] cap0[$];
  logic [7:0] cap1[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void plan(int u);
    int d;
    bit in_ok;
    d = dep[u];
    if (d == 0) begin
      p_vo[u] = valid_in && !flush;
      p_ri[u] = ready_out && !flush;
      p_do[u] = data_in;
      return;
    end
    for (int k = 0; k < n[u]; k++) begin
      if (k == 0) mv[u][k] = (pos[u][k] < d - 1) || ready_out;
      else        mv[u][k] = (pos[u][k] + 1 < pos[u][k-1]) || mv[u][k-1];
    end
    in_ok   = (n[u] == 0) || (pos[u][n[u]-1] > 0) || mv[u][n[u]-1];
    p_vo[u] = (n[u] > 0) && (pos[u][0] == d - 1) && !flush;
    p_do[u] = dat[u][0];
    p_ri[u] = in_ok && !flush;
  endfunction

  function automatic void update(int u);
    int         m;
    int         np[8];
    logic [7:0] nd[8];
    bit         out;
    if (dep[u] == 0) return;
    if (flush) begin
      n[u] = 0;
      return;
    end
    out = p_vo[u] && ready_out;
    m = 0;
    for (int k = 0; k < n[u]; k++) begin
      if (k == 0 && out) continue;
      np[m] = pos[u][k] + (mv[u][k] ? 1 : 0);
      nd[m] = dat[u][k];
      m++;
    end
    if (valid_in && p_ri[u]) begin
      np[m] = 0;
      nd[m] = data_in;
      m++;
    end
    n[u] = m;
    for (int k = 0; k < m; k++) begin
      pos[u][k] = np[k];
      dat[u][k] = nd[k];
    end
  endfunction

  task automatic compare(input int u);
    chk($sformatf("valid_out[%0d]", u), 32'(a_vo[u]), 32'(p_vo[u]));
    chk($sformatf("ready_in[%0d]", u), 32'(a_ri[u]), 32'(p_ri[u]));
    chk($sformatf("count[%0d]", u), 32'(a_cnt[u]), 32'(n[u]));
    if (p_vo[u] || dep[u] == 0)
      chk($sformatf("data_out[%0d]", u), 32'(a_do[u]), 32'(p_do[u]));
  endtask

  // Entered and left at posedge+1; outputs are compared at the falling edge.
  task automatic cyc(input logic vi, input logic [7:0] di, input logic ro, input logic fl);
    valid_in = vi; data_in = di; ready_out = ro; flush = fl;
    #4;
    for (int u = 0; u < 3; u++) begin
      plan(u);
      compare(u);
    end
    if (p_vo[0] && ready_out) cap0.push_back(p_do[0]);
    if (p_vo[1] && ready_out) cap1.push_back(p_do[1]);
    @(posedge clk);
    for (int u = 0; u < 3; u++) update(u);
    #1;
  endtask

  task automatic reset_checks();
    chk("rst_vo0", 32'(vo0), 0);
    chk("rst_do0_msb", 32'(do0[7:4]), 0);
    chk("rst_cnt0", 32'(c0), 0);
    chk("rst_ri0", 32'(ri0), 1);
    chk("rst_vo1", 32'(vo1), 0);
    chk("rst_do1", 32'(do1), 0);
    chk("rst_cnt1", 32'(c1), 0);
    chk("rst_ri1", 32'(ri1), 1);
  endtask

  task automatic mid_reset();
    valid_in = 1'b0; ready_out = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1 reset_checks();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int u = 0; u < 3; u++) n[u] = 0;
  endtask

  task automatic drain(input int cycles);
    for (int k = 0; k < cycles; k++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 reset_checks();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // Back-to-back stream with no back-pressure.
    for (int k = 0; k < 22; k++) begin
      cyc(k < 16, 8'(k + 1), 1'b1, 1'b0);
      if (k == 2) chk("lit_stream_not_yet", 32'(p_vo[0]), 0);
      if (k >= 3 && k <= 18) begin
        chk("lit_stream_vo", 32'(p_vo[0]), 1);
        chk("lit_stream_data", 32'(p_do[0]), 32'(k - 2));
      end
      if (k == 4) chk("lit_stream_d4_first", 32'(p_do[1]), 1);
      if (k == 5) chk("lit_stream_model_cnt", 32'(n[0]), 3);
      if (k == 10) chk("lit_stream_dut_cnt", 32'(c0), 3);
    end

    // Fill under back-pressure, then release.
    drain(6);
    cap0.delete();
    cyc(1'b1, 8'h0A, 1'b0, 1'b0);
    cyc(1'b1, 8'h0B, 1'b0, 1'b0);
    cyc(1'b1, 8'h0C, 1'b0, 1'b0);
    cyc(1'b1, 8'h0D, 1'b0, 1'b0);
    chk("lit_full_ri", 32'(p_ri[0]), 0);
    chk("lit_full_cnt", 32'(n[0]), 3);
    cyc(1'b1, 8'h0D, 1'b1, 1'b0);
    chk("lit_full_passthru_ri", 32'(p_ri[0]), 1);
    drain(6);
    chk("lit_full_order_n", cap0.size(), 4);
    for (int k = 0; k < 4 && k < cap0.size(); k++)
      chk("lit_full_order", 32'(cap0[k]), 32'(8'h0A + k));

    // Bubble collapsing on the 4-deep pipe.
    drain(8);
    cap1.delete();
    cyc(1'b1, 8'h05, 1'b1, 1'b0);
    cyc(1'b1, 8'h06, 1'b0, 1'b0);
    cyc(1'b1, 8'h07, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lit_bubble_cnt", 32'(n[1]), 3);
    chk("lit_bubble_dut_cnt", 32'(c1), 3);
    drain(8);
    chk("lit_bubble_n", cap1.size(), 3);
    for (int k = 0; k < 3 && k < cap1.size(); k++)
      chk("lit_bubble_order", 32'(cap1[k]), 32'(8'h05 + k));

    // Flush a full pipe while input is offered.
    drain(6);
    for (int k = 0; k < 3; k++) cyc(1'b1, 8'(8'h31 + k), 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b1, 1'b1);
    chk("lit_flush_ri", 32'(p_ri[0]), 0);
    chk("lit_flush_vo", 32'(p_vo[0]), 0);
    chk("lit_flush_cnt", 32'(n[0]), 0);
    for (int k = 0; k < 4; k++) begin
      cyc(k == 0, 8'h09, 1'b1, 1'b0);
      if (k == 2) chk("lit_flush_after_early", 32'(p_vo[0]), 0);
      if (k == 3) begin
        chk("lit_flush_after_vo", 32'(p_vo[0]), 1);
        chk("lit_flush_after_data", 32'(p_do[0]), 32'h09);
      end
    end

    // Asynchronous reset with two entries held.
    drain(6);
    cyc(1'b1, 8'hF7, 1'b0, 1'b0);
    cyc(1'b1, 8'hE6, 1'b0, 1'b0);
    chk("lit_prereset_cnt", 32'(n[0]), 2);
    chk("lit_prereset_dut_cnt", 32'(c0), 2);
    mid_reset();

    // Zero-depth pass-through.
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("lit_d0_vo", 32'(p_vo[2]), 1);
    chk("lit_d0_data", 32'(p_do[2]), 32'h5A);
    chk("lit_d0_ri", 32'(p_ri[2]), 1);
    cyc(1'b1, 8'h5A, 1'b1, 1'b1);
    chk("lit_d0_flush_vo", 32'(p_vo[2]), 0);
    chk("lit_d0_flush_ri", 32'(p_ri[2]), 0);
    cyc(1'b0, 8'h3C, 1'b0, 1'b0);
    chk("lit_d0_idle_ri", 32'(p_ri[2]), 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 50) == 0);
      if (i % 1000 == 999) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
